// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// capacity default, count width and the checksum update helper.
package imem_loader_pkg;

    localparam int CNT_W         = 16;
    localparam int MAX_WORDS_DEF = 256;

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // Running XOR checksum over data bytes.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs an MSB-first byte stream into 32-bit words and flags the byte that
// completes each word.
module byte_packer (
    input  logic        clk_i,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_r;
    logic [23:0] shift_r;

    // The completed word is presented on the same cycle as its 4th byte so
    // the parent can register it with one cycle of latency.
    assign word       = {shift_r, data_in};
    assign word_valid = accept & (cnt_r == 2'd3);

    // Shift register and byte position within the current word.
    always_ff @(posedge clk_i) begin
        if (clear) begin
            cnt_r   <= 2'd0;
            shift_r <= 24'd0;
        end else if (accept) begin
            cnt_r   <= cnt_r + 2'd1;
            shift_r <= {shift_r[15:0], data_in};
        end else begin
            cnt_r   <= cnt_r;
            shift_r <= shift_r;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot-time loader: receives length, program words and XOR checksum over a
// byte stream, writes instruction memory and releases the CPU on success.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t             state_r;
    logic               in_ready_r;
    logic               wr_en_r;
    logic [ADDR_W-1:0]  wr_addr_r;
    logic [31:0]        wr_data_r;
    logic               cpu_rst_r;
    logic               done_r;
    logic               err_r;
    logic [7:0]         acc_r;
    logic [7:0]         cnt_hi_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   word_cnt_r;

    logic               accept_s;
    logic               pack_accept_s;
    logic               pack_clear_s;
    logic [31:0]        word_s;
    logic               word_valid_s;
    logic [CNT_W-1:0]   len_s;
    logic               last_word_s;
    logic [ADDR_W-1:0]  addr_s;

    assign accept_s      = in_valid_i & in_ready_r;
    assign pack_accept_s = accept_s & (state_r == S_DATA);
    // Packer is held clear outside the data phase so a reset or abort never
    // leaves a partial word behind.
    assign pack_clear_s  = ~rst_i | (state_r != S_DATA);
    assign len_s         = {cnt_hi_r, in_data_i};
    assign last_word_s   = (word_cnt_r == (count_r - {{(CNT_W-1){1'b0}}, 1'b1}));
    assign addr_s        = ADDR_W'({word_cnt_r, 2'b00});

    byte_packer u_packer (
        .clk_i      (clk_i),
        .clear      (pack_clear_s),
        .accept     (pack_accept_s),
        .data_in    (in_data_i),
        .word       (word_s),
        .word_valid (word_valid_s)
    );

    // Load FSM with registered handshake, write and status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r    <= S_LEN_HI;
            in_ready_r <= 1'b0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= {ADDR_W{1'b0}};
            wr_data_r  <= 32'd0;
            cpu_rst_r  <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            acc_r      <= 8'd0;
            cnt_hi_r   <= 8'd0;
            count_r    <= {CNT_W{1'b0}};
            word_cnt_r <= {CNT_W{1'b0}};
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                S_LEN_HI: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        cnt_hi_r <= in_data_i;
                        state_r  <= S_LEN_LO;
                    end else begin
                        state_r  <= S_LEN_HI;
                    end
                end
                S_LEN_LO: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        count_r <= len_s;
                        if (len_s > MAX_CNT) begin
                            state_r    <= S_ERR;
                            err_r      <= 1'b1;
                            in_ready_r <= 1'b0;
                        end else if (len_s == {CNT_W{1'b0}}) begin
                            state_r <= S_CSUM;
                        end else begin
                            state_r <= S_DATA;
                        end
                    end else begin
                        state_r <= S_LEN_LO;
                    end
                end
                S_DATA: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        acc_r <= csum_update(acc_r, in_data_i);
                    end else begin
                        acc_r <= acc_r;
                    end
                    if (word_valid_s) begin
                        wr_en_r    <= 1'b1;
                        wr_addr_r  <= addr_s;
                        wr_data_r  <= word_s;
                        word_cnt_r <= word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (last_word_s) begin
                            state_r <= S_CSUM;
                        end else begin
                            state_r <= S_DATA;
                        end
                    end else begin
                        state_r <= S_DATA;
                    end
                end
                S_CSUM: begin
                    in_ready_r <= 1'b1;
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        if (in_data_i == acc_r) begin
                            state_r   <= S_DONE;
                            done_r    <= 1'b1;
                            cpu_rst_r <= 1'b1;
                        end else begin
                            state_r   <= S_ERR;
                            err_r     <= 1'b1;
                        end
                    end else begin
                        state_r <= S_CSUM;
                    end
                end
                S_DONE: begin
                    in_ready_r <= 1'b0;
                    done_r     <= 1'b1;
                    cpu_rst_r  <= 1'b1;
                end
                S_ERR: begin
                    in_ready_r <= 1'b0;
                    err_r      <= 1'b1;
                    cpu_rst_r  <= 1'b0;
                end
                default: begin
                    state_r    <= S_ERR;
                    in_ready_r <= 1'b0;
                    err_r      <= 1'b1;
                    cpu_rst_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o = in_ready_r;
    assign wr_en_o    = wr_en_r;
    assign wr_addr_o  = wr_addr_r;
    assign wr_data_o  = wr_data_r;
    assign cpu_rst_o  = cpu_rst_r;
    assign done_o     = done_r;
    assign err_o      = err_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected writes are queued as bytes
// are driven and popped when the write strobe appears.
module tb_imem_boot_loader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [7:0]  in_data_i = 8'd0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        cpu_rst_o;
    logic        done_o;
    logic        err_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_wr  = 0;
    logic        prev_wr = 1'b0;
    logic [63:0] sb[$];
    logic [31:0] img[$];
    logic [31:0] none[$];

    imem_boot_loader #(.MAX_WORDS(256), .ADDR_W(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .wr_en_o    (wr_en_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .cpu_rst_o  (cpu_rst_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: pops the scoreboard on every strobe and checks pulse width.
    always @(negedge clk_i) begin
        if (wr_en_o === 1'b1) begin
            n_wr++;
            if (sb.size() == 0)
                chk("unexpected_write", 64'(sb.size()), 64'd1);
            else
                chk("write", {wr_addr_o, wr_data_o}, sb.pop_front());
            chk("wr_pulse_width", 64'(prev_wr), 64'd0);
        end
        prev_wr = wr_en_o;
    end

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    // Drive one byte and return on the negedge after it was accepted.
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        in_data_i  = b;
        in_valid_i = 1'b1;
        while (in_ready_o !== 1'b1 && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 20) chk("ready_timeout", 64'(in_ready_o), 64'd1);
        else @(negedge clk_i);
    endtask

    task automatic run_image(input logic [15:0] cnt, input logic [31:0] words[$],
                             input bit bad_csum, input logic [7:0] bad_val, input int gap);
        logic [7:0]  acc;
        logic [7:0]  b;
        logic [31:0] w;
        acc = 8'd0;
        send(cnt[15:8]); idle(gap);
        send(cnt[7:0]);  idle(gap);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int j = 0; j < 4; j++) begin
                b   = w[31-8*j -: 8];
                acc = acc ^ b;
                if (j == 3) sb.push_back({32'(i*4), w});
                send(b);
                idle(gap);
            end
        end
        send(bad_csum ? bad_val : acc);
        in_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_ready",   64'(in_ready_o), 64'd0);
        chk("rst_wr_en",   64'(wr_en_o),    64'd0);
        chk("rst_wr_addr", 64'(wr_addr_o),  64'd0);
        chk("rst_wr_data", 64'(wr_data_o),  64'd0);
        chk("rst_cpu_rst", 64'(cpu_rst_o),  64'd0);
        chk("rst_done",    64'(done_o),     64'd0);
        chk("rst_err",     64'(err_o),      64'd0);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("ready_after_rst", 64'(in_ready_o), 64'd1);
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e, input logic c);
        chk({tag, "_done"},    64'(done_o),     64'(d));
        chk({tag, "_err"},     64'(err_o),      64'(e));
        chk({tag, "_cpu_rst"}, 64'(cpu_rst_o),  64'(c));
        chk({tag, "_ready"},   64'(in_ready_o), 64'd0);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int wr0;
        img.push_back(32'hAABBCCDD);
        img.push_back(32'h11223344);

        // Normal load, back-to-back bytes.
        do_reset();
        wr0 = n_wr;
        run_image(16'd2, img, 1'b0, 8'h00, 0);
        chk_status("normal", 1'b1, 1'b0, 1'b1);
        chk("normal_nwr", 64'(n_wr - wr0), 64'd2);
        repeat (3) @(negedge clk_i);
        chk("done_sticky", 64'(done_o), 64'd1);
        chk("hold_addr", 64'(wr_addr_o), 64'h4);
        chk("hold_data", 64'(wr_data_o), 64'h11223344);

        // Zero-length image.
        do_reset();
        wr0 = n_wr;
        run_image(16'd0, none, 1'b0, 8'h00, 0);
        chk_status("zero", 1'b1, 1'b0, 1'b1);
        chk("zero_nwr", 64'(n_wr - wr0), 64'd0);

        // Bad checksum.
        do_reset();
        wr0 = n_wr;
        run_image(16'd2, img, 1'b1, 8'h89, 0);
        chk_status("badcsum", 1'b0, 1'b1, 1'b0);
        chk("badcsum_nwr", 64'(n_wr - wr0), 64'd2);

        // Oversize count 257.
        do_reset();
        wr0 = n_wr;
        send(8'h01);
        send(8'h01);
        in_valid_i = 1'b1;
        chk("over_err",   64'(err_o),      64'd1);
        chk("over_ready", 64'(in_ready_o), 64'd0);
        repeat (8) @(negedge clk_i);
        chk_status("over", 1'b0, 1'b1, 1'b0);
        chk("over_nwr", 64'(n_wr - wr0), 64'd0);

        // Normal load with 3-cycle valid gaps.
        do_reset();
        wr0 = n_wr;
        run_image(16'd2, img, 1'b0, 8'h00, 3);
        chk_status("gaps", 1'b1, 1'b0, 1'b1);
        chk("gaps_nwr", 64'(n_wr - wr0), 64'd2);

        // Reset after the 6th byte, then a full load.
        do_reset();
        wr0 = n_wr;
        send(8'h00); send(8'h02);
        send(8'hAA); send(8'hBB); send(8'hCC);
        sb.push_back({32'h0, 32'hAABBCCDD});
        send(8'hDD);
        do_reset();
        chk("midrst_nwr", 64'(n_wr - wr0), 64'd1);
        wr0 = n_wr;
        run_image(16'd2, img, 1'b0, 8'h00, 0);
        chk_status("reload", 1'b1, 1'b0, 1'b1);
        chk("reload_nwr", 64'(n_wr - wr0), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
